// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_pkg
// Purpose  : Shared types and default constants for the CPU run controller.
//            - run_state_e    : controller state encoding
//            - c_def_sig_addr : default signature write address
//            - c_def_pass_val : default signature value meaning "pass"
// Revision : 1.0 - initial release
// ============================================================================
package cpu_run_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    DONE       = 2'd2
  } run_state_e;

  localparam logic [31:0] c_def_sig_addr = 32'h0000_0FFC;
  localparam logic [31:0] c_def_pass_val = 32'h0000_0001;

endpackage : cpu_run_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Ports    : clk   - rising-edge clock
//            rst   - asynchronous active-low reset (count -> 0)
//            clr   - synchronous clear (count -> 0)
//            en    - count enable
//            count - current value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_max = '1;
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Run controller for CPU simulation / FPGA bring-up. Sequences the
//            CPU reset, snoops the CPU<->memory bus, detects end of test
//            (signature write, stalled PC, watchdog), then freezes the CPU and
//            publishes the verdict plus bus statistics.
// Options  : PC_TRACE_EN - when defined, adds a TRACE_DEPTH-entry ring buffer
//            of fetch addresses readable through trace_idx/trace_pc.
//            When undefined, trace_pc is constant 0.
// Ports    : clk, rst (async, active-low)
//            instruct_address, data_address, data_in, mem_read, mem_write
//              - snooped CPU bus
//            cpu_rst                 - active-high reset to the CPU
//            done/pass/halted/timeout - sticky verdict flags
//            cycle_count/read_count/write_count - RUN statistics
//            trace_idx / trace_pc    - PC trace read port (0 = newest)
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 32,
  parameter int                RST_CYCLES  = 5,
  parameter int                MAX_CYCLES  = 10000,
  parameter int                HALT_CYCLES = 4,
  parameter logic [ADDR_W-1:0] SIG_ADDR    = ADDR_W'(c_def_sig_addr),
  parameter logic [DATA_W-1:0] PASS_VAL    = DATA_W'(c_def_pass_val),
  parameter int                TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              instruct_address,
  input  logic [ADDR_W-1:0]              data_address,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           mem_read,
  input  logic                           mem_write,
  output logic                           cpu_rst,
  output logic                           done,
  output logic                           pass,
  output logic                           halted,
  output logic                           timeout,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               read_count,
  output logic [CNT_W-1:0]               write_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_W-1:0]              trace_pc
);

  localparam int               c_rcnt_w   = $clog2(RST_CYCLES + 1);
  localparam int               c_run_w    = $clog2(HALT_CYCLES + 1);
  localparam logic [c_rcnt_w-1:0] c_rst_last = c_rcnt_w'(RST_CYCLES - 1);
  localparam logic [c_rcnt_w-1:0] c_rcnt_one = c_rcnt_w'(1);
  localparam logic [c_run_w-1:0]  c_halt     = c_run_w'(HALT_CYCLES);
  localparam logic [c_run_w-1:0]  c_run_one  = c_run_w'(1);
  localparam logic [CNT_W-1:0]    c_wdog_last = CNT_W'(MAX_CYCLES - 1);

  run_state_e          r_state;
  logic [c_rcnt_w-1:0] r_rst_cnt;
  logic [ADDR_W-1:0]   r_last_pc;
  logic [c_run_w-1:0]  r_run_len;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_pass;
  logic                r_halted;
  logic                r_timeout;

  logic                w_in_run;
  logic                w_pc_same;
  logic [c_run_w-1:0]  w_run_next;
  logic                w_sig_hit;
  logic                w_halt_hit;
  logic                w_wdog_hit;

  assign w_in_run   = (r_state == RUN);
  assign w_pc_same  = (instruct_address == r_last_pc);
  // Run-length including the current cycle; halt is judged on this value so
  // the stalled cycle that completes the run terminates the test.
  assign w_run_next = w_pc_same ? (r_run_len + c_run_one) : c_run_one;
  assign w_sig_hit  = mem_write && (data_address == SIG_ADDR);
  assign w_halt_hit = (w_run_next >= c_halt);
  assign w_wdog_hit = (cycle_count == c_wdog_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RESET_HOLD;
      r_rst_cnt <= '0;
      r_last_pc <= '0;
      r_run_len <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          r_rst_cnt <= r_rst_cnt + c_rcnt_one;
          if (r_rst_cnt == c_rst_last) begin
            r_state   <= RUN;
            r_cpu_rst <= 1'b0;
          end
        end
        RUN: begin
          r_run_len <= w_run_next;
          if (!w_pc_same) begin
            r_last_pc <= instruct_address;
          end
          // Fixed priority: signature, then halt, then watchdog.
          if (w_sig_hit) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_pass    <= (data_in == PASS_VAL);
          end else if (w_halt_hit) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_halted  <= 1'b1;
          end else if (w_wdog_hit) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        DONE: begin
          // Sticky: everything holds until the controller reset.
        end
        default: begin
          r_state   <= RESET_HOLD;
          r_cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rst = r_cpu_rst;
  assign done    = r_done;
  assign pass    = r_pass;
  assign halted  = r_halted;
  assign timeout = r_timeout;

  // Statistics: cleared while the CPU is held in reset, counting only in RUN.
  logic w_cnt_clr;
  assign w_cnt_clr = (r_state == RESET_HOLD);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr),
    .en    (w_in_run),
    .count (cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_read_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr),
    .en    (w_in_run && mem_read),
    .count (read_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_write_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr),
    .en    (w_in_run && mem_write),
    .count (write_count)
  );

`ifdef PC_TRACE_EN
  localparam int                  c_tidx_w = $clog2(TRACE_DEPTH);
  localparam logic [c_tidx_w-1:0] c_tidx_one = c_tidx_w'(1);

  logic [ADDR_W-1:0]   r_trace [TRACE_DEPTH];
  logic [c_tidx_w-1:0] r_wr_ptr;
  logic [c_tidx_w-1:0] w_rd_ptr;

  // Entries only change in RUN, so the buffer naturally freezes in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        r_trace[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_in_run && !w_pc_same) begin
      r_trace[r_wr_ptr] <= instruct_address;
      r_wr_ptr          <= r_wr_ptr + c_tidx_one;
    end
  end

  // r_wr_ptr points at the next free slot; newest entry is one behind it.
  assign w_rd_ptr = r_wr_ptr - c_tidx_one - trace_idx;
  assign trace_pc = r_trace[w_rd_ptr];
`else
  logic w_unused_trace_idx;
  assign w_unused_trace_idx = ^trace_idx;
  assign trace_pc           = '0;
`endif

endmodule : cpu_run_ctrl
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Directed self-checking bench for cpu_run_ctrl (MAX_CYCLES=50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] instruct_address;
  logic [ADDR_W-1:0] data_address;
  logic [DATA_W-1:0] data_in;
  logic              mem_read;
  logic              mem_write;
  logic              cpu_rst;
  logic              done;
  logic              pass;
  logic              halted;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  read_count;
  logic [CNT_W-1:0]  write_count;
  logic [2:0]        trace_idx;
  logic [ADDR_W-1:0] trace_pc;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .RST_CYCLES  (5),
    .MAX_CYCLES  (50),
    .HALT_CYCLES (4),
    .SIG_ADDR    (32'h0000_0FFC),
    .PASS_VAL    (32'h0000_0001),
    .TRACE_DEPTH (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .instruct_address (instruct_address),
    .data_address     (data_address),
    .data_in          (data_in),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .cpu_rst          (cpu_rst),
    .done             (done),
    .pass             (pass),
    .halted           (halted),
    .timeout          (timeout),
    .cycle_count      (cycle_count),
    .read_count       (read_count),
    .write_count      (write_count),
    .trace_idx        (trace_idx),
    .trace_pc         (trace_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one bus cycle, then land 1 ns after the sampling edge.
  task automatic drive(input logic [31:0] pc, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    instruct_address = pc;
    mem_read         = rd;
    mem_write        = wr;
    data_address     = addr;
    data_in          = data;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    instruct_address = '0;
    data_address     = '0;
    data_in          = '0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
  endtask

  // Pulse rst low, release it and count cycles of cpu_rst high until RUN.
  task automatic reset_and_run(input string tag, input int low_cycles);
    int n;
    bus_idle();
    rst = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_rst !== 1'b1) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_hold_cycles"}, 64'(n), 64'd5);
    chk({tag, "_cpu_rst_run"}, 64'(cpu_rst), 64'd0);
    chk({tag, "_cycle0"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    trace_idx = '0;
    bus_idle();
    rst = 1'b0;

    // Reset state after 3 cycles of rst low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_flags", 64'({done, pass, halted, timeout}), 64'd0);
    chk("rst_counts", 64'({cycle_count, read_count}), 64'd0);
    chk("rst_trace", 64'(trace_pc), 64'd0);

    // ---------------- Signature pass at RUN cycle 20 ----------------
    reset_and_run("seq1", 3);
    for (int k = 0; k < 20; k++) begin
      drive(32'(4 * (k + 1)), (k < 3), 1'b0, 32'h100, 32'h0);
    end
    chk("pass_not_done_yet", 64'(done), 64'd0);
    chk("pass_cycle_20", 64'(cycle_count), 64'd20);
    drive(32'd84, 1'b0, 1'b1, 32'h0000_0FFC, 32'h1);
    chk("pass_done", 64'(done), 64'd1);
    chk("pass_pass", 64'(pass), 64'd1);
    chk("pass_other_flags", 64'({halted, timeout}), 64'd0);
    chk("pass_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("pass_cycle_count", 64'(cycle_count), 64'd21);
    chk("pass_read_count", 64'(read_count), 64'd3);
    chk("pass_write_count", 64'(write_count), 64'd1);
    // DONE must ignore the bus and hold everything.
    for (int k = 0; k < 5; k++) begin
      drive(32'(8 * k), 1'b1, 1'b1, 32'h0000_0FFC, 32'hDEAD);
    end
    chk("frozen_cycle", 64'(cycle_count), 64'd21);
    chk("frozen_rw", 64'({read_count, write_count}), {32'd3, 32'd1});
    chk("frozen_flags", 64'({done, pass, halted, timeout, cpu_rst}), 64'b11001);

    // ---------------- Signature fail ----------------
    reset_and_run("seq2", 2);
    drive(32'd4, 1'b0, 1'b1, 32'h0000_0FFC, 32'hDEAD);
    chk("fail_flags", 64'({done, pass, halted, timeout}), 64'b1000);
    chk("fail_cycle", 64'(cycle_count), 64'd1);

    // ---------------- Halt on PC 0,4,8,8,8,8 ----------------
    reset_and_run("seq3", 2);
    drive(32'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("halt_not_yet", 64'(done), 64'd0);
    drive(32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("halt_flags", 64'({done, pass, halted, timeout}), 64'b1010);
    chk("halt_cycle", 64'(cycle_count), 64'd6);

    // ---------------- Halt and signature in the same cycle ----------------
    reset_and_run("seq4", 2);
    drive(32'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32'd8, 1'b0, 1'b1, 32'h0000_0FFC, 32'h1);
    chk("prio_flags", 64'({done, pass, halted, timeout}), 64'b1100);
    chk("prio_write_count", 64'(write_count), 64'd1);

    // ---------------- Watchdog (MAX_CYCLES=50) ----------------
    reset_and_run("seq5", 2);
    for (int k = 0; k < 49; k++) begin
      drive(32'(4 * (k + 1)), (k < 10), (k < 10), 32'h200, 32'h1);
    end
    chk("wdog_not_yet", 64'(done), 64'd0);
    drive(32'd200, 1'b0, 1'b0, 32'h200, 32'h0);
    chk("wdog_flags", 64'({done, pass, halted, timeout}), 64'b1001);
    chk("wdog_cycle", 64'(cycle_count), 64'd50);
    chk("wdog_reads", 64'(read_count), 64'd10);
    chk("wdog_writes", 64'(write_count), 64'd10);
`ifdef PC_TRACE_EN
    trace_idx = 3'd0;
    #1;
    chk("trace_newest", 64'(trace_pc), 64'd200);
    trace_idx = 3'd1;
    #1;
    chk("trace_idx1", 64'(trace_pc), 64'd196);
    trace_idx = 3'd7;
    #1;
    chk("trace_idx7", 64'(trace_pc), 64'd172);
`else
    trace_idx = 3'd5;
    #1;
    chk("trace_off", 64'(trace_pc), 64'd0);
`endif
    trace_idx = 3'd0;

    // ---------------- Mid-run reset at cycle 30 ----------------
    reset_and_run("seq6", 2);
    for (int k = 0; k < 30; k++) begin
      drive(32'(4 * (k + 1)), (k < 5), 1'b0, 32'h300, 32'h0);
    end
    chk("mid_cycle30", 64'(cycle_count), 64'd30);
    chk("mid_reads5", 64'(read_count), 64'd5);
    rst = 1'b0;
    #1;
    chk("mid_async_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("mid_async_counts", 64'({cycle_count, read_count}), 64'd0);
    chk("mid_async_flags", 64'({done, pass, halted, timeout}), 64'd0);
    reset_and_run("seq7", 2);
    drive(32'd4, 1'b0, 1'b1, 32'h0000_0FFC, 32'h1);
    chk("after_mid_flags", 64'({done, pass, halted, timeout}), 64'b1100);
    chk("after_mid_cycle", 64'(cycle_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_cpu_run_ctrl
`default_nettype wire
